// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO stream reader: buffer entry layout and
// occupancy encoding of the 2-entry output buffer.
package fifo_stream_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry registered output buffer: head feeds the stream, tail holds the
// second word under backpressure. Push must not be asserted while full.
module stream_skid_buf2
    import fifo_stream_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             push_last,
    input  logic             ready,
    output logic             valid,
    output logic             full,
    output logic [width-1:0] head_data,
    output logic             head_last
);

    typedef struct packed {
        logic [width-1:0] data;
        logic             last;
    } buf_entry_t;

    occ_e       occ_q, occ_d;
    buf_entry_t head_q, head_d;
    buf_entry_t tail_q, tail_d;
    buf_entry_t in_entry;
    logic       drain;

    assign in_entry  = '{data: push_data, last: push_last};
    assign valid     = (occ_q != OCC_EMPTY);
    assign full      = (occ_q == OCC_FULL);
    assign drain     = valid & ready;
    assign head_data = head_q.data;
    assign head_last = head_q.last;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = in_entry;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, drain})
                    // simultaneous push and drain: new word becomes head directly
                    2'b11: head_d = in_entry;
                    2'b10: begin
                        tail_d = in_entry;
                        occ_d  = OCC_FULL;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_FULL: begin
                if (drain) begin
                    head_d = tail_q;
                    if (push) tail_d = in_entry;
                    else      occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream, tagging every
// burst_len-th word as last and counting delivered words.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned len_width = 4,
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [len_width-1:0] cfg_burst_len,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_read_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_data,
    output logic                 out_last,
    output logic [cnt_width-1:0] words_out
);

    localparam logic [len_width-1:0] LEN_ONE = {{(len_width-1){1'b0}}, 1'b1};
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [len_width-1:0] beat_q;
    logic [len_width-1:0] eff_len;
    logic                 last_flag;
    logic                 buf_full;
    logic                 drain;

    assign eff_len   = (cfg_burst_len == '0) ? LEN_ONE : cfg_burst_len;
    // >= rather than == so a mid-burst shrink of cfg_burst_len closes the burst
    assign last_flag = (beat_q >= eff_len - LEN_ONE);
    assign fifo_pop  = rst_n & enable & ~fifo_empty & ~buf_full;
    assign drain     = out_valid & out_ready;

    stream_skid_buf2 #(
        .width(width)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_pop),
        .push_data (fifo_read_data),
        .push_last (last_flag),
        .ready     (out_ready),
        .valid     (out_valid),
        .full      (buf_full),
        .head_data (out_data),
        .head_last (out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (fifo_pop) begin
            beat_q <= last_flag ? '0 : beat_q + LEN_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (drain) begin
            words_out <= words_out + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a simple show-ahead FIFO model.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  cfg_burst_len;
    logic        fifo_empty;
    logic [7:0]  fifo_read_data;
    logic        fifo_pop;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic [7:0]  cap_data [$];
    logic        cap_last [$];

    always #5 clk = ~clk;

    assign fifo_empty     = (rd_ptr == wr_ptr);
    assign fifo_read_data = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 1;
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
        end
    end

    fifo_stream_reader #(
        .width    (8),
        .len_width(4),
        .cnt_width(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_burst_len (cfg_burst_len),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_pop      (fifo_pop),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .words_out     (words_out)
    );

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        cfg_burst_len = 4'd1;
        #1 rst_n = 1'b0;
        push_word(8'h5A);
        repeat (3) @(negedge clk);
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_out); end
        checks++; if (out_data !== 8'h00 || out_last !== 1'b0) begin errors++; $display("FAIL reset_data got=%h/%b exp=00/0", out_data, out_last); end
        rst_n = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL release_pop got=%b exp=1", fifo_pop); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1) begin errors++; $display("FAIL first_word got=%b/%h/%b exp=1/5a/1", out_valid, out_data, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || words_out !== 16'd1) begin errors++; $display("FAIL first_drain got=%b/%0d exp=0/1", out_valid, words_out); end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_d [4];
        logic       exp_l [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        cfg_burst_len = 4'd2;
        out_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_word(exp_d[i]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== exp_l[i]) begin
                errors++; $display("FAIL stream_%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_last, exp_d[i], exp_l[i]);
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || words_out !== 16'd4) begin errors++; $display("FAIL stream_end got=%b/%0d exp=0/4", out_valid, words_out); end
    endtask

    task automatic test_backpressure();
        int unsigned start_rd;
        int budget;
        cfg_burst_len = 4'd5;
        out_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        start_rd = rd_ptr;
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        repeat (6) begin
            @(negedge clk);
        end
        checks++; if (rd_ptr - start_rd != 2) begin errors++; $display("FAIL bp_pops got=%0d exp=2", rd_ptr - start_rd); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_pop_gate got=%b exp=0", fifo_pop); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold got=%b/%h/%b exp=1/01/0", out_valid, out_data, out_last); end
        cap_data.delete();
        cap_last.delete();
        out_ready = 1'b1;
        budget = 20;
        while ((out_valid || !fifo_empty) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++; if (budget == 0) begin errors++; $display("FAIL bp_timeout got=expired exp=drained"); end
        checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", cap_data.size()); end
        for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== 8'(i + 1) || cap_last[i] !== (i == 4)) begin
                errors++; $display("FAIL bp_word_%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 8'(i + 1), (i == 4));
            end
        end
        checks++; if (words_out !== 16'd5) begin errors++; $display("FAIL bp_words got=%0d exp=5", words_out); end
    endtask

    task automatic test_burst_zero();
        cfg_burst_len = 4'd0;
        out_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        push_word(8'hA0);
        push_word(8'hA1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_last !== 1'b1) begin errors++; $display("FAIL len0_a0 got=%b/%h/%b exp=1/a0/1", out_valid, out_data, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_last !== 1'b1) begin errors++; $display("FAIL len0_a1 got=%b/%h/%b exp=1/a1/1", out_valid, out_data, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || words_out !== 16'd2) begin errors++; $display("FAIL len0_end got=%b/%0d exp=0/2", out_valid, words_out); end
    endtask

    task automatic test_enable();
        int unsigned held_rd;
        int budget;
        cfg_burst_len = 4'd4;
        out_ready = 1'b1;
        enable = 1'b1;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) push_word(8'hB0 + 8'(i));
        repeat (3) @(negedge clk);
        checks++; if (out_data !== 8'hB2 || out_last !== 1'b0) begin errors++; $display("FAIL en_third got=%h/%b exp=b2/0", out_data, out_last); end
        enable = 1'b0;
        #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL en_gate got=%b exp=0", fifo_pop); end
        held_rd = rd_ptr;
        repeat (5) @(negedge clk);
        checks++; if (rd_ptr != held_rd || out_valid !== 1'b0) begin errors++; $display("FAIL en_hold got=%0d/%b exp=%0d/0", rd_ptr, out_valid, held_rd); end
        checks++; if (words_out !== 16'd3) begin errors++; $display("FAIL en_drained got=%0d exp=3", words_out); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hB3 || out_last !== 1'b1) begin errors++; $display("FAIL en_resume got=%b/%h/%b exp=1/b3/1", out_valid, out_data, out_last); end
        @(negedge clk);
        checks++; if (out_data !== 8'hB4 || out_last !== 1'b0) begin errors++; $display("FAIL en_next got=%h/%b exp=b4/0", out_data, out_last); end
        budget = 10;
        while ((out_valid || !fifo_empty) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++; if (budget == 0 || words_out !== 16'd6) begin errors++; $display("FAIL en_total got=%0d exp=6", words_out); end
    endtask

    task automatic test_reset_mid();
        cfg_burst_len = 4'd3;
        out_ready = 1'b1;
        enable = 1'b1;
        apply_reset();
        @(negedge clk);
        push_word(8'hC0);
        push_word(8'hC1);
        repeat (4) @(negedge clk);
        checks++; if (words_out !== 16'd2) begin errors++; $display("FAIL mid_pre got=%0d exp=2", words_out); end
        out_ready = 1'b0;
        push_word(8'hC2);
        push_word(8'hC3);
        push_word(8'hC4);
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_last !== 1'b1 || fifo_pop !== 1'b0) begin errors++; $display("FAIL mid_full got=%b/%h/%b/%b exp=1/c2/1/0", out_valid, out_data, out_last, fifo_pop); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_pop !== 1'b0) begin errors++; $display("FAIL mid_async got=%b/%h/%b exp=0/00/0", out_valid, out_data, fifo_pop); end
        @(negedge clk);
        cfg_burst_len = 4'd2;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC4 || out_last !== 1'b0 || words_out !== 16'd0) begin errors++; $display("FAIL mid_restart got=%b/%h/%b/%0d exp=1/c4/0/0", out_valid, out_data, out_last, words_out); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || words_out !== 16'd1) begin errors++; $display("FAIL mid_end got=%b/%0d exp=0/1", out_valid, words_out); end
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        cfg_burst_len = 4'd1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_burst_zero();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
